ps2_key_tracker: RTL

- PS/2 receive front end that feeds the game control path's `kbData` input.
- Receives device-to-host frames on PS2_CLK/PS2_DAT and decodes make, break (F0) and extended (E0) sequences.
- Drives `heldData`: the scan code of the most recently pressed key still held, or 8'h00 when no key is held.
- The control path relies on 8'h00 as its key-release indication (pause/resume edge detection).

---
 rtl/ps2_key_tracker_if.sv | 20 ++
 rtl/ps2_key_tracker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker_if.sv
// PS/2 receive lines plus the decoded key outputs of ps2_key_tracker.
// The tracker uses the slave view; the device/consumer side uses master.
interface ps2_key_tracker_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] heldData;
  logic       codeValid;
  logic [7:0] rxByte;
  logic       frameErr;

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output heldData, codeValid, rxByte, frameErr
  );

  modport master (
    output PS2_CLK, PS2_DAT,
    input  heldData, codeValid, rxByte, frameErr
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 receiver and make/break/extended decoder reporting the held key (8'h00 = none).
// Optional macro PS2_EXT_KEYS_EN: track E0-prefixed keys instead of discarding them.
module ps2_key_tracker #(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 500
) (
  input  logic Clock,
  input  logic reset,
  ps2_key_tracker_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_DECODE
  } state_e;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          clk_edge, clk_fall, dat_s;

  state_e        state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q, stop_q;
  logic [TW-1:0] tout_q;
  logic          brk_pend_q, ext_pend_q;
  logic [7:0]    held_q, held_d;
  logic [7:0]    rx_q;
  logic          code_valid_q, frame_err_q;
  logic          ext_ok;

  // Synchronizers and filter idle high, matching an undriven PS/2 bus.
  // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], bus.PS2_DAT};
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    clk_edge   = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d   = ~filt_q;
        clk_edge = 1'b1;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign clk_fall = clk_edge & filt_q;
  assign dat_s    = dat_sync_q[1];

`ifdef PS2_EXT_KEYS_EN
  assign ext_ok = 1'b1;
`else
  assign ext_ok = ~ext_pend_q;
`endif

  // Held-key update is resolved while checking so it lands with codeValid.
  always_comb begin
    held_d = held_q;
    if (shift_q != 8'hF0 && shift_q != 8'hE0 && ext_ok) begin
      if (!brk_pend_q)
        held_d = shift_q;
      else if (shift_q == held_q)
        held_d = 8'h00;
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      stop_q       <= 1'b0;
      tout_q       <= '0;
      brk_pend_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
      held_q       <= 8'h00;
      rx_q         <= 8'h00;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tout_q <= '0;
          if (clk_fall && !dat_s) begin
            state_q   <= S_RECV;
            bit_cnt_q <= '0;
          end
        end
        S_RECV: begin
          if (clk_fall) begin
            tout_q    <= '0;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q < 4'd8) begin
              shift_q <= {dat_s, shift_q[7:1]};
            end else if (bit_cnt_q == 4'd8) begin
              parity_q <= dat_s;
            end else begin
              stop_q  <= dat_s;
              state_q <= S_CHECK;
            end
          end else if (clk_edge) begin
            tout_q <= '0;
          end else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tout_q      <= '0;
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            tout_q <= tout_q + 1'b1;
          end
        end
        S_CHECK: begin
          if ((^{shift_q, parity_q}) && stop_q) begin
            rx_q         <= shift_q;
            code_valid_q <= 1'b1;
            held_q       <= held_d;
            state_q      <= S_DECODE;
          end else begin
            frame_err_q <= 1'b1;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_DECODE: begin
          if (rx_q == 8'hF0) begin
            brk_pend_q <= 1'b1;
          end else if (rx_q == 8'hE0) begin
            ext_pend_q <= 1'b1;
          end else begin
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.heldData  = held_q;
  assign bus.codeValid = code_valid_q;
  assign bus.rxByte    = rx_q;
  assign bus.frameErr  = frame_err_q;

endmodule
